// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer: 32-step radix-2 restoring division beside the EX-stage ALU.
// Quotient lands in lo, remainder in hi; ready pulses for one cycle when they are valid.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        stall,
  output logic        ready,
  output logic [31:0] lo,
  output logic [31:0] hi,
  output logic        div_by_zero
);
  typedef enum logic [1:0] {IDLE, BUSY, ZERO, DONE} state_t;

  state_t      state, nxt;
  logic [5:0]  cnt;
  logic [31:0] rem, quo, dvs;
  logic        sign_q, sign_r;
  logic [31:0] a_abs, b_abs;
  logic [32:0] shl, trial;
  logic [31:0] rem_n, quo_n;

  assign a_abs = (signed_div && a[31]) ? -a : a;
  assign b_abs = (signed_div && b[31]) ? -b : b;

  // One restoring step: shift in the next dividend bit, keep the trial difference if it did not borrow.
  always_comb begin
    shl   = {rem, quo[31]};
    trial = shl - {1'b0, dvs};
    rem_n = shl[31:0];
    quo_n = {quo[30:0], 1'b0};
    if (!trial[32]) begin
      rem_n = trial[31:0];
      quo_n = {quo[30:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt   = state;
    stall = 1'b0;
    case (state)
      IDLE: begin
        stall = start & ~cancel;
        if (start) nxt = (b == 32'd0) ? ZERO : BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == 6'd31) nxt = DONE;
      end
      ZERO: begin
        stall = 1'b1;
        nxt   = DONE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (cancel) nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= 6'd0;
      rem         <= 32'd0;
      quo         <= 32'd0;
      dvs         <= 32'd0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      ready       <= 1'b0;
      lo          <= 32'd0;
      hi          <= 32'd0;
      div_by_zero <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: if (start && !cancel) begin
          cnt <= 6'd0;
          rem <= 32'd0;
          if (b == 32'd0) begin
            quo <= a;  // raw dividend is reported as the remainder
          end else begin
            quo    <= a_abs;
            dvs    <= b_abs;
            sign_q <= signed_div & (a[31] ^ b[31]);
            sign_r <= signed_div & a[31];
          end
        end
        BUSY: if (!cancel) begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            lo          <= sign_q ? -quo_n : quo_n;
            hi          <= sign_r ? -rem_n : rem_n;
            div_by_zero <= 1'b0;
            ready       <= 1'b1;
          end
        end
        ZERO: if (!cancel) begin
          lo          <= 32'hFFFF_FFFF;
          hi          <= quo;
          div_by_zero <= 1'b1;
          ready       <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed sign/zero/cancel/reset/held-start cases plus random operands,
// checked against an arithmetic reference model.
module tb_div_seq;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, signed_div = 1'b0, cancel = 1'b0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        stall, ready, div_by_zero;
  logic [31:0] lo, hi;

  int tests = 0, fails = 0;
  logic [31:0] exp_lo = 32'd0, exp_hi = 32'd0;
  logic        exp_z = 1'b0;

  div_seq dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .a(a), .b(b),
    .cancel(cancel), .stall(stall), .ready(ready), .lo(lo), .hi(hi), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: MIPS semantics by plain arithmetic; signed uses 64-bit ints so MIN/-1 just wraps.
  function automatic void model(input bit sd, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] ql, output logic [31:0] qh, output logic z);
    longint sx, sy, q, r;
    z = 1'b0;
    if (y == 32'd0) begin
      ql = 32'hFFFF_FFFF; qh = x; z = 1'b1;
    end else if (sd) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      ql = q[31:0];
      qh = r[31:0];
    end else begin
      ql = x / y;
      qh = x % y;
    end
  endfunction

  // Called at a negedge: present a request, let E0 take it, then leave start at keep.
  task automatic launch(input bit sd, input logic [31:0] x, input logic [31:0] y, input bit keep);
    signed_div = sd; a = x; b = y; start = 1'b1;
    #1 chk("stall_req", stall, 1'b1);
    @(posedge clk);
    @(negedge clk);
    start = keep;
  endtask

  // Called at the negedge after E0: wait for ready, check latency, stall count and results.
  task automatic finish_op(input bit sd, input logic [31:0] x, input logic [31:0] y);
    int n, st;
    n = 1; st = 0;
    model(sd, x, y, exp_lo, exp_hi, exp_z);
    #1;
    while (!ready && n < 100) begin
      if (stall) st++;
      @(negedge clk); #1;
      n++;
    end
    chk("latency", n, (y == 32'd0) ? 2 : 33);
    chk("stall_cycles", st + 1, (y == 32'd0) ? 2 : 33);
    chk("stall_in_done", stall, 1'b0);
    chk("lo", lo, exp_lo);
    chk("hi", hi, exp_hi);
    chk("div_by_zero", div_by_zero, exp_z);
    @(negedge clk); #1;
    chk("ready_pulse_end", ready, 1'b0);
    chk("lo_hold", lo, exp_lo);
  endtask

  initial begin
    int seen;
    logic [31:0] rx, ry;
    bit rs;

    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1'b0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_dbz", div_by_zero, 1'b0);
    chk("rst_stall", stall, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    launch(0, 32'd100, 32'd7, 0);            finish_op(0, 32'd100, 32'd7);
    launch(1, -32'sd7, 32'd2, 0);            finish_op(1, -32'sd7, 32'd2);
    launch(1, 32'd7, -32'sd2, 0);            finish_op(1, 32'd7, -32'sd2);
    launch(1, 32'h8000_0000, 32'hFFFF_FFFF, 0); finish_op(1, 32'h8000_0000, 32'hFFFF_FFFF);
    launch(1, 32'd5, 32'd0, 0);              finish_op(1, 32'd5, 32'd0);
    launch(0, 32'd9, 32'd3, 0);              finish_op(0, 32'd9, 32'd3);

    // cancel once the counter has reached 10
    launch(0, 32'd100, 32'd7, 0);
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    #1 chk("cancel_stall", stall, 1'b0);
    seen = 0;
    repeat (36) begin
      if (ready) seen++;
      @(negedge clk); #1;
    end
    chk("cancel_no_ready", seen, 0);
    chk("cancel_lo_kept", lo, exp_lo);
    chk("cancel_hi_kept", hi, exp_hi);
    launch(0, 32'd50, 32'd5, 0);             finish_op(0, 32'd50, 32'd5);

    // async reset between edges mid-BUSY
    launch(1, -32'sd1000, 32'd3, 0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_lo", lo, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_ready", ready, 1'b0);
    chk("arst_stall", stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // start held through DONE: one pulse, next op taken in the following IDLE cycle
    launch(0, 32'd9, 32'd3, 1);
    finish_op(0, 32'd9, 32'd3);
    chk("held_stall_idle", stall, 1'b1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    finish_op(0, 32'd9, 32'd3);

    for (int i = 0; i < 16; i++) begin
      rs = 1'($urandom % 2);
      rx = $urandom;
      case ($urandom % 4)
        0:       ry = 32'd0;
        1:       ry = $urandom_range(1, 15);
        2:       ry = $urandom;
        default: ry = 32'hFFFF_FFFF;
      endcase
      launch(rs, rx, ry, 0);
      finish_op(rs, rx, ry);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
